// File: rtl/edge_event_arbiter.sv
// Edge-event collector: synchronizes NUM_CH async lines, latches edges as
// pending events and serves them round-robin over a valid/ready stream.
module edge_event_arbiter #(
    parameter int                NUM_CH      = 4,
    parameter logic [NUM_CH-1:0] EDGE_MASK   = {NUM_CH{1'b1}},
    parameter int                SYNC_STAGES = 2,
    localparam int               CW          = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset_qual_n,
    input  logic [NUM_CH-1:0] signal_in,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CW-1:0]     evt_ch,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] overflow,
    input  logic [NUM_CH-1:0] ovf_clr
);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    logic [NUM_CH-1:0]      sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] warm_q;
    logic [NUM_CH-1:0]      armed_q, armed_d;
    logic [NUM_CH-1:0]      pending_q, pending_d;
    logic [NUM_CH-1:0]      overflow_q, overflow_d;
    logic [NUM_CH-1:0]      s, asrt, edge_s, gnt_mask, ovf_set;
    logic                   warm;
    state_t                 state_q;
    logic                   evt_valid_q;
    logic [CW-1:0]          evt_ch_q;
    logic [CW-1:0]          ptr_q;
    logic [CW-1:0]          cand, gnt_idx;
    logic                   gnt_found, do_gnt;

    // warm_q keeps reset-value synchronizer contents from looking like a level
    always_ff @(posedge clk or negedge reset_qual_n) begin
        if (!reset_qual_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            warm_q <= '0;
        end else begin
            sync_q[0] <= signal_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            warm_q <= {warm_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign s       = sync_q[SYNC_STAGES-1];
    assign warm    = warm_q[SYNC_STAGES-1];
    assign asrt    = ~(s ^ EDGE_MASK);
    assign edge_s  = warm ? (armed_q & asrt) : '0;
    assign armed_d = warm ? ~asrt : armed_q;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CW'((int'(ptr_q) + k) % NUM_CH);
            if (!gnt_found && pending_q[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign do_gnt     = gnt_found && (state_q == IDLE || evt_ready);
    assign gnt_mask   = do_gnt ? (NUM_CH'(1) << gnt_idx) : '0;
    assign ovf_set    = edge_s & pending_q & ~gnt_mask;
    assign pending_d  = (pending_q & ~gnt_mask) | edge_s;
    assign overflow_d = (overflow_q & ~ovf_clr) | ovf_set;

    always_ff @(posedge clk or negedge reset_qual_n) begin
        if (!reset_qual_n) begin
            armed_q    <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            armed_q    <= armed_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or negedge reset_qual_n) begin
        if (!reset_qual_n) begin
            state_q     <= IDLE;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            ptr_q       <= CW'(NUM_CH - 1);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt_found) begin
                        state_q     <= OFFER;
                        evt_valid_q <= 1'b1;
                        evt_ch_q    <= gnt_idx;
                        ptr_q       <= gnt_idx;
                    end
                end
                OFFER: begin
                    if (evt_ready) begin
                        if (gnt_found) begin
                            evt_ch_q <= gnt_idx;
                            ptr_q    <= gnt_idx;
                        end else begin
                            state_q     <= IDLE;
                            evt_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    evt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule
